// File: rtl/uart_rx_deserializer_if.sv
// Serial-line side of the UART byte receiver: the rx wire plus the recovered
// byte stream and its status strobes.
interface uart_rx_deserializer_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_framing_error;
  logic       rx_endofpacket;
  logic       rx_idle;

  modport master (
    output rx,
    input  rx_data, rx_data_ready, rx_framing_error, rx_endofpacket, rx_idle
  );

  modport slave (
    input  rx,
    output rx_data, rx_data_ready, rx_framing_error, rx_endofpacket, rx_idle
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: oversampled start/data/stop recovery, framing-error
// detection and idle-gap end-of-packet signalling.
module uart_rx_deserializer #(
  parameter int clk_freq   = 50_000_000,
  parameter int baud       = 115200,
  parameter int oversample = 8,
  parameter int gap_bits   = 16
) (
  input logic                  clk,
  input logic                  reset,
  uart_rx_deserializer_if.slave bus
);

  localparam int DIV     = clk_freq / (baud * oversample);
  localparam int DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(oversample);
  localparam int GAP_MAX = gap_bits * oversample;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_deserializer: clk_freq/(baud*oversample) must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t             state;
  logic               rx_sync_p0;
  logic               rx_sync_p1;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [SC_W-1:0]    sc;
  logic [2:0]         bc;
  logic [7:0]         shreg;
  logic [GAP_W-1:0]   gap_cnt;
  logic               armed;
  logic [7:0]         rx_data_q;
  logic               ready_q;
  logic               ferr_q;
  logic               eop_q;
  logic               rxs;

  assign rxs  = rx_sync_p1;
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // Stage p0/p1: two-flop synchronizer on the asynchronous line, idle-high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= bus.rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DIV_W'(1);
  end

  // Receive FSM and gap counter advance only on oversample ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sc        <= '0;
      bc        <= '0;
      gap_cnt   <= '0;
      armed     <= 1'b0;
      rx_data_q <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      eop_q   <= 1'b0;
      if (tick) begin
        // Any low sample restarts the idle measurement; leaving IDLE needs a low sample too
        if (!rxs) begin
          gap_cnt <= '0;
        end else if (state == S_IDLE && gap_cnt != GAP_W'(GAP_MAX)) begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_W'(GAP_MAX - 1) && armed) begin
            eop_q <= 1'b1;
            armed <= 1'b0;
          end
        end

        unique case (state)
          S_IDLE: begin
            if (!rxs) begin
              state <= S_START;
              sc    <= '0;
            end
          end
          S_START: begin
            if (sc == SC_W'(oversample / 2 - 1)) begin
              sc <= '0;
              bc <= '0;
              state <= rxs ? S_IDLE : S_DATA;
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
          S_DATA: begin
            sc <= sc + SC_W'(1);
            if (sc == SC_W'(oversample - 1)) begin
              shreg <= {rxs, shreg[7:1]};
              bc    <= bc + 3'd1;
              if (bc == 3'd7) state <= S_STOP;
            end
          end
          S_STOP: begin
            sc <= sc + SC_W'(1);
            if (sc == SC_W'(oversample - 1)) begin
              if (rxs) begin
                rx_data_q <= shreg;
                ready_q   <= 1'b1;
                armed     <= 1'b1;
                state     <= S_IDLE;
              end else begin
                ferr_q <= 1'b1;
                state  <= S_BREAK;
              end
            end
          end
          S_BREAK: begin
            if (rxs) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data          = rx_data_q;
  assign bus.rx_data_ready    = ready_q;
  assign bus.rx_framing_error = ferr_q;
  assign bus.rx_endofpacket   = eop_q;
  assign bus.rx_idle          = (gap_cnt == GAP_W'(GAP_MAX));

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 50 MHz / 115200 baud / x8
// oversampling (432 clocks per bit).
module tb_uart_rx_deserializer;

  localparam int BIT = 432;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_rx_deserializer_if bus();

  uart_rx_deserializer #(
    .clk_freq(50_000_000), .baud(115200), .oversample(8), .gap_bits(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_ready = 0, n_ferr = 0, n_eop = 0, n_viol = 0;
  int t_ready = 0, t_start = 0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_data_ready) begin
      n_ready++;
      last_byte = bus.rx_data;
      got_q.push_back(bus.rx_data);
      t_ready = cyc;
    end
    if (bus.rx_framing_error) n_ferr++;
    if (bus.rx_endofpacket) n_eop++;
    if (bus.rx_data_ready && (bus.rx_framing_error || bus.rx_endofpacket)) n_viol++;
  end

  task automatic drive_bit(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_bits);
    t_start = cyc;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(stop, stop_bits * BIT);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", bus.rx_data); end
    total++; if (bus.rx_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.rx_data_ready); end
    total++; if (bus.rx_framing_error !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", bus.rx_framing_error); end
    total++; if (bus.rx_endofpacket !== 1'b0) begin bad++; $display("FAIL reset_eop got=%b want=0", bus.rx_endofpacket); end
    total++; if (bus.rx_idle !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b want=0", bus.rx_idle); end
    reset = 1'b0;
  endtask

  task automatic test_gap_no_data();
    drive_bit(1'b1, 10 * BIT);
    total++; if (bus.rx_idle !== 1'b0) begin bad++; $display("FAIL gap_idle_early got=%b want=0", bus.rx_idle); end
    drive_bit(1'b1, 10 * BIT);
    total++; if (bus.rx_idle !== 1'b1) begin bad++; $display("FAIL gap_idle_late got=%b want=1", bus.rx_idle); end
    total++; if (n_eop !== 0) begin bad++; $display("FAIL gap_no_eop got=%0d want=0", n_eop); end
  endtask

  task automatic test_single_byte();
    int r0, f0, lat;
    r0 = n_ready; f0 = n_ferr;
    send_byte(8'hA5, 1'b1, 1);
    lat = t_ready - t_start;
    total++; if (n_ready !== r0 + 1) begin bad++; $display("FAIL single_count got=%0d want=%0d", n_ready - r0, 1); end
    total++; if (last_byte !== 8'hA5) begin bad++; $display("FAIL single_value got=%h want=a5", last_byte); end
    total++; if (bus.rx_data !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h want=a5", bus.rx_data); end
    total++; if (lat < 4050 || lat > 4170) begin bad++; $display("FAIL single_latency got=%0d want=4050..4170", lat); end
    total++; if (n_ferr !== f0) begin bad++; $display("FAIL single_no_ferr got=%0d want=%0d", n_ferr, f0); end
  endtask

  task automatic test_back_to_back();
    int r0, e0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h5A;
    r0 = n_ready; e0 = n_eop;
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1, 1);
    total++; if (n_ready !== r0 + 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", n_ready - r0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q.size() <= r0 + i) begin
        bad++; $display("FAIL b2b_value%0d got=none want=%h", i, exp_b[i]);
      end else if (got_q[r0 + i] !== exp_b[i]) begin
        bad++; $display("FAIL b2b_value%0d got=%h want=%h", i, got_q[r0 + i], exp_b[i]);
      end
    end
    drive_bit(1'b1, 15 * BIT);
    total++; if (n_eop !== e0) begin bad++; $display("FAIL eop_early got=%0d want=%0d", n_eop - e0, 0); end
    drive_bit(1'b1, 3 * BIT);
    total++; if (n_eop !== e0 + 1) begin bad++; $display("FAIL eop_once got=%0d want=1", n_eop - e0); end
    total++; if (bus.rx_idle !== 1'b1) begin bad++; $display("FAIL eop_idle got=%b want=1", bus.rx_idle); end
    drive_bit(1'b1, 4 * BIT);
    total++; if (n_eop !== e0 + 1) begin bad++; $display("FAIL eop_no_repeat got=%0d want=1", n_eop - e0); end
  endtask

  task automatic test_glitch();
    int r0, f0;
    logic [7:0] d0;
    r0 = n_ready; f0 = n_ferr; d0 = bus.rx_data;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 2 * BIT);
    total++; if (n_ready !== r0) begin bad++; $display("FAIL glitch_ready got=%0d want=0", n_ready - r0); end
    total++; if (n_ferr !== f0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", n_ferr - f0); end
    total++; if (bus.rx_data !== d0) begin bad++; $display("FAIL glitch_data got=%h want=%h", bus.rx_data, d0); end
    total++; if (int'(dut.state) !== 0) begin bad++; $display("FAIL glitch_state got=%0d want=0", int'(dut.state)); end
  endtask

  task automatic test_framing();
    int r0, f0;
    r0 = n_ready; f0 = n_ferr;
    send_byte(8'h3C, 1'b0, 2);
    drive_bit(1'b1, 2 * BIT);
    total++; if (n_ferr !== f0 + 1) begin bad++; $display("FAIL frame_ferr got=%0d want=1", n_ferr - f0); end
    total++; if (n_ready !== r0) begin bad++; $display("FAIL frame_no_ready got=%0d want=0", n_ready - r0); end
    total++; if (bus.rx_data !== 8'h5A) begin bad++; $display("FAIL frame_hold got=%h want=5a", bus.rx_data); end
    send_byte(8'h81, 1'b1, 1);
    drive_bit(1'b1, BIT);
    total++; if (n_ready !== r0 + 1) begin bad++; $display("FAIL frame_next_count got=%0d want=1", n_ready - r0); end
    total++; if (last_byte !== 8'h81) begin bad++; $display("FAIL frame_next_value got=%h want=81", last_byte); end
    total++; if (n_ferr !== f0 + 1) begin bad++; $display("FAIL frame_next_ferr got=%0d want=1", n_ferr - f0); end
  endtask

  task automatic test_reset_mid_byte();
    int r0, f0;
    logic [7:0] b;
    b = 8'hC3;
    r0 = n_ready; f0 = n_ferr;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BIT);
    drive_bit(b[4], BIT / 2);
    reset = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", bus.rx_data); end
    total++; if ({bus.rx_data_ready, bus.rx_framing_error, bus.rx_endofpacket, bus.rx_idle} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_flags got=%b want=0000",
                      {bus.rx_data_ready, bus.rx_framing_error, bus.rx_endofpacket, bus.rx_idle});
    end
    drive_bit(1'b1, 2 * BIT);
    total++; if (n_ready !== r0 || n_ferr !== f0) begin
      bad++; $display("FAIL rstmid_no_pulse got=%0d/%0d want=0/0", n_ready - r0, n_ferr - f0);
    end
    send_byte(8'h12, 1'b1, 1);
    drive_bit(1'b1, BIT);
    total++; if (n_ready !== r0 + 1) begin bad++; $display("FAIL rstmid_next_count got=%0d want=1", n_ready - r0); end
    total++; if (bus.rx_data !== 8'h12) begin bad++; $display("FAIL rstmid_next_value got=%h want=12", bus.rx_data); end
    total++; if (n_ferr !== f0) begin bad++; $display("FAIL rstmid_next_ferr got=%0d want=0", n_ferr - f0); end
  endtask

  task automatic test_exclusive_pulses();
    total++; if (n_viol !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", n_viol); end
  endtask

  initial begin
    bus.rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_gap_no_data();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid_byte();
    test_exclusive_pulses();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-to-byte receiver for the 8N1 UART link carrying the 16-bit little-endian number stream. It oversamples the asynchronous `rx` line, recovers bytes LSB-first, and flags framing errors. After a valid byte it reports end-of-packet once the line has stayed idle for a programmable gap. It sits directly under the number-packing layer, feeding `rx_data` / `rx_data_ready` / `rx_endofpacket` into the byte-to-number assembler.

## Interface
- `clk_freq`, 50_000_000: system clock frequency in Hz.
- `baud`, 115200: line bit rate.
- `oversample`, 8: ticks per bit; power of two, ≥4.
- `gap_bits`, 16: idle bit-times after the last stop bit that mark end-of-packet.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high.
- `rx`  input  1  asynchronous serial line; idle high.
- `rx_data`  output  8  last received byte; holds its value until the next valid byte.
- `rx_data_ready`  output  1  one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_framing_error`  output  1  one-cycle pulse when the stop bit is sampled low.
- `rx_endofpacket`  output  1  one-cycle pulse when the idle gap elapses after ≥1 valid byte.
- `rx_idle`  output  1  high while the gap counter is saturated (line idle ≥ `gap_bits`).

## Operation
- **Synchronizer:** two flops on `rx`, reset to 1. All decisions use the synchronized value `rxs`.
- **Tick generator:**
  - `DIV = clk_freq/(baud*oversample)`, integer-truncated; elaboration error if `DIV < 2`.
  - Counter runs 0..DIV-1 free-running; `tick` is high one cycle at DIV-1.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Sample counter `sc` (log2(oversample) bits); bit counter `bc` (3 bits).
- **IDLE:** on a tick with `rxs`=0, go to START with `sc`=0.
- **START:**
  - Count ticks. At `sc`=oversample/2-1 (mid start bit), sample `rxs`.
  - If 1: glitch; return to IDLE with no output.
  - If 0: go to DATA with `sc`=0 and `bc`=0.
- **DATA:**
  - At `sc`=oversample-1 (mid bit), shift `rxs` into shift register MSB, shifting right, so the byte arrives LSB-first.
  - Increment `bc`; after `bc`=7 is sampled, go to STOP.
- **STOP:** at the mid-stop-bit sample:
  - `rxs`=1: load `rx_data` from the shifter, pulse `rx_data_ready`, arm the packet flag, go to IDLE.
  - `rxs`=0: pulse `rx_framing_error`, leave `rx_data` unchanged, go to BREAK.
- **BREAK:** wait for a tick with `rxs`=1, then go to IDLE. A framing error does not disarm the packet flag.
- **Gap counter:**
  - Counts ticks while in IDLE with `rxs`=1; saturates at `gap_bits*oversample`.
  - Cleared on any tick with `rxs`=0 and on leaving IDLE.
  - On reaching saturation with the packet flag armed: pulse `rx_endofpacket` and clear the flag.
  - `rx_idle` equals the saturated condition.
- **Back-to-back bytes:** a start bit may begin on the first tick after the STOP decision. No minimum inter-byte gap.
- **Reset mid-byte:** the partial byte is discarded with no pulses. The FSM returns to IDLE, the packet flag clears, the gap counter clears, and the synchronizer presets to 1.

## Timing
- Reset values: `rx_data`=0x00; `rx_data_ready`, `rx_framing_error`, `rx_endofpacket`, `rx_idle` all 0.
- `rx_data_ready` asserts the cycle after the tick on which the stop bit is sampled.
  - Nominal delay from the falling start edge: 9.5 bit times + sampling jitter ≤ 1 tick + 2 synchronizer cycles + 1.
- `rx_data_ready` and `rx_framing_error` are mutually exclusive. `rx_endofpacket` never coincides with `rx_data_ready`.
- `rx_endofpacket` follows the last valid stop-bit sample by (`gap_bits*oversample` + ≤oversample/2) ticks.
- After saturation, `rx_idle` stays high until the next low sample. `rx_endofpacket` does not repeat.
- Tolerates ±3% baud mismatch at `oversample`=8.

## Test plan
All scenarios use defaults: DIV=54, bit = 432 cycles.
- **Single byte:** send 0xA5 with stop=1 → `rx_data`=0xA5, one `rx_data_ready` pulse ~4110±60 cycles after the start edge, no error.
- **Back-to-back:** send 0x00, 0xFF, 0x5A with no idle between them → three ready pulses in order, values 0x00/0xFF/0x5A. Then, after 16 idle bit-times, exactly one `rx_endofpacket`.
- **Glitch rejection:** drive `rx` low for 100 cycles → no pulses, FSM back in IDLE, `rx_data` unchanged.
- **Framing error:** send 0x3C with stop=0 held for 2 bit times, then idle → one `rx_framing_error` pulse, no ready pulse, `rx_data` keeps the prior value. The next 0x81 is received correctly.
- **Reset mid-byte:** assert `reset` one cycle during bit 4 of 0xC3, then send 0x12 → no pulse for 0xC3, `rx_data`=0x12, all outputs 0 in the cycle after reset.
- **Gap without data:** idle line for 20 bit-times after reset → `rx_idle` goes high, `rx_endofpacket` never pulses.
